// File: rtl/memory_access_ctrl_pkg.sv
// Shared definitions for the memory access controller and the load-shift stage:
// FSM encoding, access size codes, one-hot positions and bus payload structs.
package memory_access_ctrl_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned OH_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [SIZE_W-1:0] SZ_BYTE   = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF   = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD   = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_DOUBLE = 2'b11;

  localparam int unsigned OH_BYTE   = 0;
  localparam int unsigned OH_HALF   = 1;
  localparam int unsigned OH_WORD   = 2;
  localparam int unsigned OH_DOUBLE = 3;

  typedef struct packed {
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_wr_t;

  typedef struct packed {
    logic [OFF_W-1:0] offset;
    logic [OH_W-1:0]  size_oh;
    logic             is_sign;
    logic             is_store;
    logic             misalign;
  } out_meta_t;

  function automatic logic is_misaligned(input logic [SIZE_W-1:0] size,
                                         input logic [OFF_W-1:0]  off);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF:   mis = off[0];
      SZ_WORD:   mis = |off[1:0];
      SZ_DOUBLE: mis = |off;
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [OH_W-1:0] size_onehot(input logic [SIZE_W-1:0] size);
    return OH_W'(1) << size;
  endfunction

endpackage

// File: rtl/memory_store_align.sv
// Places right-justified store data at its byte lane and builds the byte strobe.
module memory_store_align
  import memory_access_ctrl_pkg::*;
(
  input  logic [SIZE_W-1:0] i_size,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_wdata_c,
  output logic [STRB_W-1:0] o_wstrb_c
);

  logic [STRB_W-1:0] w_base;

  always_comb begin
    w_base = 8'h01;
    case (i_size)
      SZ_BYTE:   w_base = 8'h01;
      SZ_HALF:   w_base = 8'h03;
      SZ_WORD:   w_base = 8'h0F;
      SZ_DOUBLE: w_base = 8'hFF;
      default:   w_base = 8'h01;
    endcase
    o_wstrb_c = w_base << i_offset;
    o_wdata_c = i_data << {i_offset, 3'b000};
  end

endmodule

// File: rtl/memory_access_ctrl.sv
// Single-outstanding load/store controller between execute stage, memory bus
// and load-shift stage; misaligned accesses complete without touching the bus.
module memory_access_ctrl
  import memory_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_is_store,
  input  logic [SIZE_W-1:0] in_size,
  input  logic              in_is_sign,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [STRB_W-1:0] mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pre_data,
  output logic [OFF_W-1:0]  out_data_offset,
  output logic [OH_W-1:0]   out_size_oh,
  output logic              out_is_sign,
  output logic              out_is_store,
  output logic              out_misalign
);

  state_e            r_state;
  state_e            w_next;
  logic              w_accept;
  logic              w_mis;
  logic [DATA_W-1:0] w_st_wdata;
  logic [STRB_W-1:0] w_st_wstrb;
  logic [ADDR_W-1:0] r_addr;
  mem_wr_t           r_wr;
  out_meta_t         r_meta;
  logic [DATA_W-1:0] r_pre_data;

  memory_store_align u_store_align (
    .i_size    (in_size),
    .i_offset  (in_addr[OFF_W-1:0]),
    .i_data    (in_wdata),
    .o_wdata_c (w_st_wdata),
    .o_wstrb_c (w_st_wstrb)
  );

  assign w_accept = in_valid && in_ready;
  assign w_mis    = is_misaligned(in_size, in_addr[OFF_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_mis ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_req_ready) w_next = ST_WAIT;
      ST_WAIT: if (mem_resp_valid) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Handshake strobes are state decodes, held low while reset is asserted.
  always_comb begin
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE: in_ready      = 1'b1;
        ST_REQ:  mem_req_valid = 1'b1;
        ST_DONE: out_valid     = 1'b1;
        default: ;
      endcase
    end
  end

  // Request and result fields latch on accept; only the response data arrives later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_wr       <= '0;
      r_meta     <= '0;
      r_pre_data <= '0;
    end else if (w_accept) begin
      r_meta.offset   <= in_addr[OFF_W-1:0];
      r_meta.size_oh  <= size_onehot(in_size);
      r_meta.is_sign  <= in_is_sign && !in_is_store && (in_size != SZ_DOUBLE);
      r_meta.is_store <= in_is_store;
      r_meta.misalign <= w_mis;
      r_pre_data      <= '0;
      if (!w_mis) begin
        r_addr <= {in_addr[ADDR_W-1:OFF_W], 3'b000};
        if (in_is_store) r_wr <= '{wen: 1'b1, wdata: w_st_wdata, wstrb: w_st_wstrb};
        else             r_wr <= '0;
      end
    end else if (r_state == ST_WAIT && mem_resp_valid && !r_meta.is_store) begin
      r_pre_data <= mem_resp_data;
    end
  end

  assign mem_req_addr    = r_addr;
  assign mem_req_wen     = r_wr.wen;
  assign mem_req_wdata   = r_wr.wdata;
  assign mem_req_wstrb   = r_wr.wstrb;
  assign out_pre_data    = r_pre_data;
  assign out_data_offset = r_meta.offset;
  assign out_size_oh     = r_meta.size_oh;
  assign out_is_sign     = r_meta.is_sign;
  assign out_is_store    = r_meta.is_store;
  assign out_misalign    = r_meta.misalign;

endmodule

// File: tb/tb_memory_access_ctrl.sv
// Scoreboard bench for memory_access_ctrl: directed scenarios then random traffic
// against a byte-level reference model.
module tb_memory_access_ctrl;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  typedef struct {
    logic [63:0] pre;
    logic [2:0]  off;
    logic [3:0]  oh;
    logic        sign;
    logic        store;
    logic        mis;
    int          lat;
    int          acc;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_addr;
  logic [63:0] in_wdata;
  logic        in_is_store;
  logic [1:0]  in_size;
  logic        in_is_sign;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_req_wen;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pre_data;
  logic [2:0]  out_data_offset;
  logic [3:0]  out_size_oh;
  logic        out_is_sign;
  logic        out_is_store;
  logic        out_misalign;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit directed = 1'b1;
  bit no_resp = 1'b0;
  int garbage_rate = 0;
  int ready_low = 0;
  int out_low = 0;

  req_t        q_req[$];
  out_t        q_out[$];
  logic [63:0] q_resp[$];

  memory_access_ctrl #(.ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_is_store(in_is_store), .in_size(in_size), .in_is_sign(in_is_sign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pre_data(out_pre_data),
    .out_data_offset(out_data_offset), .out_size_oh(out_size_oh), .out_is_sign(out_is_sign),
    .out_is_store(out_is_store), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request at a negedge and wait (bounded) for it to be accepted.
  task automatic issue(input logic [63:0] a, input logic [63:0] wd, input logic st,
                       input logic [1:0] sz, input logic sg, input logic [63:0] rd,
                       input int lat, input bit push_out);
    int   nb;
    int   off;
    bit   mis;
    bit   ok;
    req_t r;
    out_t o;
    nb  = 1 << sz;
    off = int'(a[2:0]);
    mis = (off % nb) != 0;
    in_valid = 1'b1; in_addr = a; in_wdata = wd; in_is_store = st; in_size = sz; in_is_sign = sg;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 64'(in_ready), 64'(1));
    if (!mis) begin
      r.addr  = {a[63:3], 3'b000};
      r.wen   = st;
      r.wdata = st ? (wd << (8 * off)) : 64'h0;
      r.wstrb = 8'h00;
      if (st) for (int i = 0; i < nb; i++) r.wstrb[off + i] = 1'b1;
      q_req.push_back(r);
      if (push_out) q_resp.push_back(rd);
    end
    o.pre   = (mis || st) ? 64'h0 : rd;
    o.off   = a[2:0];
    o.oh    = 4'h0;
    o.oh[sz] = 1'b1;
    o.sign  = sg && !st && (sz != 2'b11);
    o.store = st;
    o.mis   = mis;
    o.lat   = lat;
    o.acc   = cyc;
    if (push_out) q_out.push_back(o);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Bus side: ready generation, request monitor/stability, response generator.
  logic [138:0] req_hold;
  bit           req_hold_v;
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; req_hold_v = 1'b0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (rst) begin mem_req_ready = 1'b0; req_hold_v = 1'b0; continue; end
      if (req_hold_v)
        chk("req_stable", 64'({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb} != req_hold), 64'(0));
      req_hold_v = 1'b0;
      if (mem_req_valid) begin
        chk("in_ready_in_req", 64'(in_ready), 64'(0));
        if (ready_low > 0) begin mem_req_ready = 1'b0; ready_low--; end
        else mem_req_ready = directed ? 1'b1 : 1'($urandom_range(0, 9) < 6);
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
      if (mem_req_valid && mem_req_ready) begin
        req_t e;
        int   d;
        if (q_req.size() == 0) begin
          chk("unexpected_bus_req", 64'(1), 64'(0));
        end else begin
          e = q_req.pop_front();
          chk("req_addr", mem_req_addr, e.addr);
          chk("req_wen", 64'(mem_req_wen), 64'(e.wen));
          chk("req_wdata", mem_req_wdata, e.wdata);
          chk("req_wstrb", 64'(mem_req_wstrb), 64'(e.wstrb));
        end
        if (!no_resp) begin
          d = directed ? 0 : int'($urandom_range(0, 3));
          repeat (d + 1) @(negedge clk);
          mem_resp_valid = 1'b1;
          mem_resp_data  = (q_resp.size() != 0) ? q_resp.pop_front() : 64'hDEAD_BEEF_0BAD_F00D;
        end
      end else begin
        if (mem_req_valid) begin
          req_hold   = {mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb};
          req_hold_v = 1'b1;
        end
        if (int'($urandom_range(0, 99)) < garbage_rate) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = {$urandom, $urandom};
        end
      end
    end
  end

  // Result side: out_ready generation, latency, stability and scoreboard compare.
  logic [74:0] out_hold;
  bit          out_hold_v;
  bit          seen;
  initial begin
    out_ready = 1'b0; out_hold_v = 1'b0; seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin out_ready = 1'b0; out_hold_v = 1'b0; seen = 1'b0; continue; end
      if (out_hold_v)
        chk("out_stable", 64'({out_valid, out_pre_data, out_data_offset, out_size_oh, out_is_sign,
                               out_is_store, out_misalign} != out_hold), 64'(0));
      out_hold_v = 1'b0;
      if (out_valid) begin
        chk("in_ready_in_done", 64'(in_ready), 64'(0));
        if (out_low > 0) begin out_ready = 1'b0; out_low--; end
        else out_ready = directed ? 1'b1 : 1'($urandom_range(0, 2) != 0);
        if (q_out.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          if (!seen && q_out[0].lat >= 0)
            chk("out_latency", 64'(cyc - q_out[0].acc), 64'(q_out[0].lat));
          seen = 1'b1;
          if (out_ready) begin
            out_t e;
            e = q_out.pop_front();
            chk("out_pre_data", out_pre_data, e.pre);
            chk("out_offset", 64'(out_data_offset), 64'(e.off));
            chk("out_size_oh", 64'(out_size_oh), 64'(e.oh));
            chk("out_flags", 64'({out_is_sign, out_is_store, out_misalign}), 64'({e.sign, e.store, e.mis}));
            seen = 1'b0;
          end else begin
            out_hold = {out_valid, out_pre_data, out_data_offset, out_size_oh, out_is_sign,
                        out_is_store, out_misalign};
            out_hold_v = 1'b1;
          end
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0;
    in_is_store = 1'b0; in_size = 2'b00; in_is_sign = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_req_fields", 64'({mem_req_valid, mem_req_wen, mem_req_wstrb}), 64'(0));
    chk("rst_req_addr", mem_req_addr, 64'h0);
    chk("rst_out_fields", 64'({out_data_offset, out_size_oh, out_is_sign, out_is_store, out_misalign}), 64'(0));
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);

    // Aligned half load, signed store byte, misaligned word load.
    issue(64'h1006, 64'h0, 1'b0, 2'b01, 1'b1, 64'h8877_6655_4433_2211, 3, 1'b1);
    repeat (4) @(negedge clk);
    issue(64'h2003, 64'hAB, 1'b1, 2'b00, 1'b1, 64'h1111_2222_3333_4444, 3, 1'b1);
    repeat (4) @(negedge clk);
    issue(64'h3002, 64'h0, 1'b0, 2'b10, 1'b0, 64'h0, 1, 1'b1);
    repeat (3) @(negedge clk);

    // Backpressure on both handshakes.
    ready_low = 3; out_low = 2;
    issue(64'h5008, 64'h0123_4567_89AB_CDEF, 1'b1, 2'b11, 1'b0, 64'h0, -1, 1'b1);
    repeat (10) @(negedge clk);

    // Reset while waiting for a response; later responses must be ignored.
    no_resp = 1'b1;
    issue(64'h4000, 64'h0, 1'b0, 2'b11, 1'b0, 64'h0, -1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rst_mid_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    garbage_rate = 100;
    #1 chk("rst_mid_after_in_ready", 64'(in_ready), 64'(1));
    chk("rst_mid_pre_data", out_pre_data, 64'h0);
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_quiet", 64'({out_valid, mem_req_valid, in_ready}), 64'(3'b001));
    end
    garbage_rate = 0; no_resp = 1'b0;
    @(negedge clk);

    // Random traffic with random backpressure, latency and stray responses.
    directed = 1'b0; garbage_rate = 20;
    for (int n = 0; n < 300; n++) begin
      logic [63:0] a;
      logic [1:0]  sz;
      logic [2:0]  m;
      a  = {$urandom, $urandom};
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) begin
        m = 3'((1 << sz) - 1);
        a[2:0] = a[2:0] & ~m;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, -1, 1'b1);
    end
    for (int i = 0; i < 2000 && (q_out.size() != 0 || q_req.size() != 0); i++) @(negedge clk);
    chk("drain", 64'(q_out.size() + q_req.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
